keypad_4x4_scanner: RTL and testbench
=====================================

Name: keypad_4x4_scanner

Overview:
- Operand-entry front end for the calculator: scans a 4x4 matrix keypad, debounces presses, rejects multi-key ghosting, and emits one 4-bit key code per press with a one-cycle strobe.
- Drives the keypad column lines and reads its row lines. Feeds the operand/select registers that currently come from slide switches.
- Input-side counterpart of the 7-segment display path.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, column-step rate in Hz; tick period = CLK_HZ/SCAN_HZ cycles. Must be ≥2 cycles.
- DEBOUNCE_SCANS, 4, consecutive identical full sweeps required to accept a press and to accept a release. Range 1..15.
- REPEAT_SWEEPS, 250, auto-repeat interval in sweeps. Used only with AUTOREPEAT_EN.

Ports:
- CLK_100MHz  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- row  input  4  keypad rows, active-low (pulled up externally), asynchronous to the clock.
- col  output  4  keypad column drive, active-low one-hot, registered.
- key_code  output  4  code of the last accepted key; held until the next acceptance.
- key_valid  output  1  one-cycle pulse when key_code is updated or repeated.
- key_held  output  1  high from acceptance until the release is debounced.

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters 0, row synchronizer=4'b1111. Reset is asynchronous and takes effect mid-sweep or mid-debounce with no residual pulse.
- row passes through a 2-flop synchronizer. All decisions use the synchronized value rs.
- Tick divider counts 0..CLK_HZ/SCAN_HZ-1 and pulses tick for 1 cycle on terminal count.
- On each tick:
  - Sample ~rs as the hits for the current column index c.
  - Advance c to (c+1) mod 4, wrapping 3→0. col = ~(1<<c).
  - A column is therefore driven for one full tick period before it is sampled.
- Sweep result is evaluated on the tick that samples c=3. It is one of:
  - NONE: zero hits across all 4 columns.
  - KEY(k): exactly one hit.
  - MULTI: more than one hit. MULTI is treated identically to NONE.
- Key map (row r, col c): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D. Codes: digits = their value, A=10, B=11, C=12, D=13, *=14, #=15.
- FSM steps only at sweep end. cnt is the debounce counter.
  - IDLE:
    - KEY(k) → DEBOUNCE, cand=k, cnt=1.
    - Otherwise stay.
  - DEBOUNCE:
    - KEY(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS → PRESSED: key_code=cand, key_held=1, key_valid=1 for exactly the next clock cycle.
    - KEY(other) → stay in DEBOUNCE, cand=other, cnt=1.
    - NONE → IDLE, cnt=0.
  - PRESSED:
    - KEY(cand) → stay.
    - Otherwise → RELEASE, cnt=1 if NONE, else cnt=0.
  - RELEASE:
    - NONE → cnt+1. When cnt reaches DEBOUNCE_SCANS → IDLE, key_held=0.
    - KEY(cand) → PRESSED with no new pulse.
    - KEY(other) → cnt=0, stay in RELEASE. No rollover: a new key requires a full debounced release first.
- DEBOUNCE_SCANS=1: acceptance happens on the first matching sweep, i.e. IDLE→PRESSED directly with a pulse.
- Latency from a stable press: at most (DEBOUNCE_SCANS+1) sweeps + 3 cycles to key_valid.
- key_valid is never high for 2 consecutive cycles.

Optional Feature:
- AUTOREPEAT_EN defined:
  - In PRESSED, a sweep counter runs from acceptance.
  - Every REPEAT_SWEEPS matching sweeps, key_valid pulses again with key_code unchanged.
  - The counter clears on leaving PRESSED.
  - A RELEASE→PRESSED bounce restarts the count without a pulse.
- Not defined: exactly one key_valid per accepted press. No repeat counter is synthesized.

Test Plan:
- Common bench setup: CLK_HZ=1000, SCAN_HZ=100, DEBOUNCE_SCANS=3, so tick=10 cycles and sweep=40 cycles.
- Reset and scan: rst_n low, then high → col=1110, then 1101/1011/0111 every 10 cycles, wrapping to 1110. key_valid=0, key_held=0 throughout.
- Clean press of key "5" (row1 low while col1 driven) for 8 sweeps → single key_valid pulse with key_code=5 at ≤4 sweeps+3 cycles. key_held=1 until 3 NONE sweeps after release.
- Bounce: "9" present in sweeps 1,2, absent in sweep 3, present in 4–7 → no pulse until sweep 6, then exactly one pulse with key_code=9.
- Ghosting: "1" and "D" held together for 10 sweeps → no key_valid, key_held=0. Then release "D" → pulse with key_code=1 after 3 sweeps.
- No rollover: hold "#", then add "0" and release "#" → "0" is not accepted until all keys are released for 3 sweeps. key_code stays 15.
- Reset mid-debounce: assert rst_n low during DEBOUNCE → outputs return to reset values immediately. With AUTOREPEAT_EN and REPEAT_SWEEPS=5, holding "7" for 20 sweeps → pulses at acceptance and every 5 sweeps after, key_code=7 each time.

Source files
------------

// File: rtl/keypad_4x4_scanner_if.sv
// Keypad scanner signal bundle: matrix lines toward the keypad and the
// accepted-key outputs toward the operand/select registers.
// master = scanner side, slave = keypad/consumer side.
interface keypad_4x4_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held
  );
endinterface

// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner with sweep-level debouncing and ghost rejection.
// Walks an active-low column one step per scan tick. It collects the row hits
// of a full sweep and accepts a single-key sweep pattern only after it has
// repeated DEBOUNCE_SCANS times. It then emits the key code with a one-cycle
// key_valid strobe.
// Optional feature macro: AUTOREPEAT_EN -- while a key stays pressed,
// key_valid re-fires every REPEAT_SWEEPS matching sweeps.
module keypad_4x4_scanner #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SWEEPS  = 250
) (
  input  logic                 CLK_100MHz,
  input  logic                 rst_n,
  keypad_4x4_scanner_if.master kp
);

  localparam int               DIV       = CLK_HZ / SCAN_HZ;
  localparam int               DIV_W     = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [3:0]       DB_TARGET = 4'(DEBOUNCE_SCANS);

  // A bad parameter set is a build error, not a silent misbehaviour.
  if (DIV < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SWEEPS < 1) begin : gBadParams
    $error("keypad_4x4_scanner: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]       rowMeta_q, rowSync_q;
  logic [DIV_W-1:0] divCnt_q;
  logic             tick;
  logic [1:0]       colIdx_q, colNext;
  logic [3:0]       col_q;
  logic [11:0]      hitsAcc_q;
  logic [15:0]      sweepHits;
  logic             sweepEnd;
  logic [4:0]       hitCount;
  logic [3:0]       hitIdx;
  logic             oneKey;
  logic [3:0]       sweepCode;
  logic             candMatch;

  state_t     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] keyCode_q, keyCode_d;
  logic       keyValid_q, keyValid_d;
  logic       keyHeld_q, keyHeld_d;

`ifdef AUTOREPEAT_EN
  localparam int             RPT_W      = $clog2(REPEAT_SWEEPS + 1);
  localparam logic [RPT_W-1:0] RPT_TARGET = RPT_W'(REPEAT_SWEEPS);
  logic [RPT_W-1:0] rptCnt_q, rptCnt_d;
`endif

  assign tick     = (divCnt_q == DIV_LAST);
  assign colNext  = colIdx_q + 2'd1;
  assign sweepEnd = tick && (colIdx_q == 2'd3);

  // Two-flop synchronizer for the asynchronous row lines (idle = all high).
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      rowMeta_q <= 4'b1111;
      rowSync_q <= 4'b1111;
    end else begin
      rowMeta_q <= kp.row;
      rowSync_q <= rowMeta_q;
    end
  end

  // Scan-rate divider: tick is high on the terminal count cycle.
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      divCnt_q <= '0;
    end else if (tick) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_q + DIV_W'(1);
    end
  end

  // Sample the column driven for the whole last tick, then step to the next.
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      colIdx_q  <= 2'd0;
      col_q     <= 4'b1110;
      hitsAcc_q <= '0;
    end else if (tick) begin
      colIdx_q <= colNext;
      col_q    <= ~(4'b0001 << colNext);
      case (colIdx_q)
        2'd0:    hitsAcc_q[3:0]  <= ~rowSync_q;
        2'd1:    hitsAcc_q[7:4]  <= ~rowSync_q;
        2'd2:    hitsAcc_q[11:8] <= ~rowSync_q;
        default: hitsAcc_q       <= '0;
      endcase
    end
  end

  // Classify the finished sweep (column 3 comes straight from the synchronizer).
  always_comb begin
    sweepHits = {~rowSync_q, hitsAcc_q};
    hitCount  = 5'd0;
    hitIdx    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (sweepHits[i]) begin
        hitCount = hitCount + 5'd1;
        hitIdx   = 4'(i);
      end
    end
    oneKey = (hitCount == 5'd1);
    // hitIdx = column*4 + row; map to the printed keypad legend.
    case (hitIdx)
      4'd0:    sweepCode = 4'd1;
      4'd1:    sweepCode = 4'd4;
      4'd2:    sweepCode = 4'd7;
      4'd3:    sweepCode = 4'd14;
      4'd4:    sweepCode = 4'd2;
      4'd5:    sweepCode = 4'd5;
      4'd6:    sweepCode = 4'd8;
      4'd7:    sweepCode = 4'd0;
      4'd8:    sweepCode = 4'd3;
      4'd9:    sweepCode = 4'd6;
      4'd10:   sweepCode = 4'd9;
      4'd11:   sweepCode = 4'd15;
      4'd12:   sweepCode = 4'd10;
      4'd13:   sweepCode = 4'd11;
      4'd14:   sweepCode = 4'd12;
      default: sweepCode = 4'd13;
    endcase
    candMatch = oneKey && (sweepCode == cand_q);
  end

  // Debounce/acceptance FSM; it only moves on sweep boundaries (multi-key = none).
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
`ifdef AUTOREPEAT_EN
    rptCnt_d   = rptCnt_q;
`endif
    if (sweepEnd) begin
`ifdef AUTOREPEAT_EN
      rptCnt_d = '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (oneKey) begin
            cand_d = sweepCode;
            if (DB_TARGET == 4'd1) begin
              state_d    = PRESSED;
              cnt_d      = 4'd0;
              keyCode_d  = sweepCode;
              keyHeld_d  = 1'b1;
              keyValid_d = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (candMatch) begin
            if (cnt_q + 4'd1 == DB_TARGET) begin
              state_d    = PRESSED;
              cnt_d      = 4'd0;
              keyCode_d  = cand_q;
              keyHeld_d  = 1'b1;
              keyValid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (oneKey) begin
            cand_d = sweepCode;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (candMatch) begin
`ifdef AUTOREPEAT_EN
            if (rptCnt_q + RPT_W'(1) == RPT_TARGET) begin
              keyValid_d = 1'b1;
            end else begin
              rptCnt_d = rptCnt_q + RPT_W'(1);
            end
`endif
          end else if (!oneKey && DB_TARGET == 4'd1) begin
            state_d   = IDLE;
            cnt_d     = 4'd0;
            keyHeld_d = 1'b0;
          end else begin
            state_d = RELEASE;
            cnt_d   = oneKey ? 4'd0 : 4'd1;
          end
        end
        RELEASE: begin
          if (!oneKey) begin
            if (cnt_q + 4'd1 == DB_TARGET) begin
              state_d   = IDLE;
              cnt_d     = 4'd0;
              keyHeld_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else if (candMatch) begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = 4'd0;
          end
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      cnt_q      <= 4'd0;
      keyCode_q  <= 4'd0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
`ifdef AUTOREPEAT_EN
      rptCnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
`ifdef AUTOREPEAT_EN
      rptCnt_q   <= rptCnt_d;
`endif
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = keyCode_q;
  assign kp.key_valid = keyValid_q;
  assign kp.key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Directed testbench for keypad_4x4_scanner.
// A small behavioural keypad turns the pressed-key mask plus the driven
// columns into row levels. Checks are immediate assertions in one linear
// initial block. Build with AUTOREPEAT_EN defined to exercise auto-repeat.
module tb_keypad_4x4_scanner;

  logic        CLK_100MHz;
  logic        rst_n;
  logic [15:0] pressMask;
  logic [3:0]  rowDrive;

  int evalCount   = 0;
  int failCount   = 0;
  int pulseCount  = 0;
  int doubleCount = 0;
  int base;
  logic prevValid = 1'b0;

  // Pressed-key mask bits, row-major: bit index = row*4 + column.
  localparam int K1    = 0;
  localparam int K5    = 5;
  localparam int K7    = 8;
  localparam int K9    = 10;
  localparam int K0    = 13;
  localparam int KHASH = 14;
  localparam int KD    = 15;

  keypad_4x4_scanner_if kif ();

  keypad_4x4_scanner #(
    .CLK_HZ        (1000),
    .SCAN_HZ       (100),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SWEEPS (5)
  ) dut (
    .CLK_100MHz(CLK_100MHz),
    .rst_n     (rst_n),
    .kp        (kif)
  );

  // Free-running clock.
  initial CLK_100MHz = 1'b0;
  always #5 CLK_100MHz = ~CLK_100MHz;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rowDrive = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressMask[r*4 + c] && !kif.col[c]) rowDrive[r] = 1'b0;
      end
    end
  end
  assign kif.row = rowDrive;

  // Pulse monitor: counts key_valid pulses and any back-to-back highs.
  always @(negedge CLK_100MHz) begin
    if (kif.key_valid) pulseCount++;
    if (kif.key_valid && prevValid) doubleCount++;
    prevValid = kif.key_valid;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    evalCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask);
    pressMask = mask;
  endtask

  // Wait for n sweep boundaries (col wrapping 0111 -> 1110), each bounded.
  task automatic waitSweeps(input int n);
    logic [3:0] prevCol;
    bit         found;
    for (int s = 0; s < n; s++) begin
      found   = 1'b0;
      prevCol = kif.col;
      for (int cyc = 0; cyc < 100 && !found; cyc++) begin
        @(negedge CLK_100MHz);
        if (prevCol == 4'b0111 && kif.col == 4'b1110) found = 1'b1;
        prevCol = kif.col;
      end
      evalCount++;
      assert (found)
      else begin
        failCount++;
        $error("[TB] FAIL sweep_wait: observed no boundary expected boundary within 100 cycles");
      end
    end
    #1;
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h0000);
    repeat (3) @(negedge CLK_100MHz);
    checkOutput("rst_col",   int'(kif.col), 4'b1110);
    checkOutput("rst_code",  int'(kif.key_code), 0);
    checkOutput("rst_valid", int'(kif.key_valid), 0);
    checkOutput("rst_held",  int'(kif.key_held), 0);

    // Column walk after reset: one column per 10 cycles.
    @(negedge CLK_100MHz);
    rst_n = 1'b1;
    checkOutput("scan_c0_start", int'(kif.col), 4'b1110);
    repeat (9) @(negedge CLK_100MHz);
    checkOutput("scan_c0_end", int'(kif.col), 4'b1110);
    @(negedge CLK_100MHz);
    checkOutput("scan_c1", int'(kif.col), 4'b1101);
    repeat (10) @(negedge CLK_100MHz);
    checkOutput("scan_c2", int'(kif.col), 4'b1011);
    repeat (10) @(negedge CLK_100MHz);
    checkOutput("scan_c3", int'(kif.col), 4'b0111);
    repeat (10) @(negedge CLK_100MHz);
    checkOutput("scan_wrap",  int'(kif.col), 4'b1110);
    checkOutput("scan_valid", int'(kif.key_valid), 0);
    checkOutput("scan_held",  int'(kif.key_held), 0);

    // Clean press of "5" for 8 sweeps.
    base = pulseCount;
    applyStimulus(16'(1) << K5);
    waitSweeps(2);
    checkOutput("k5_early_pulses", pulseCount - base, 0);
    checkOutput("k5_early_held", int'(kif.key_held), 0);
    waitSweeps(1);
    checkOutput("k5_valid", int'(kif.key_valid), 1);
    checkOutput("k5_code",  int'(kif.key_code), 5);
    checkOutput("k5_held",  int'(kif.key_held), 1);
    @(negedge CLK_100MHz);
    checkOutput("k5_valid_drop", int'(kif.key_valid), 0);
    waitSweeps(5);
    checkOutput("k5_single_pulse", pulseCount - base, 1);
    applyStimulus(16'h0000);
    waitSweeps(2);
    checkOutput("k5_rel_held", int'(kif.key_held), 1);
    waitSweeps(1);
    checkOutput("k5_rel_done", int'(kif.key_held), 0);

    // Bounce on "9": present, present, absent, then present.
    base = pulseCount;
    applyStimulus(16'(1) << K9);
    waitSweeps(2);
    applyStimulus(16'h0000);
    waitSweeps(1);
    applyStimulus(16'(1) << K9);
    waitSweeps(2);
    checkOutput("k9_no_early", pulseCount - base, 0);
    waitSweeps(1);
    checkOutput("k9_valid", int'(kif.key_valid), 1);
    checkOutput("k9_code",  int'(kif.key_code), 9);
    waitSweeps(1);
    checkOutput("k9_single_pulse", pulseCount - base, 1);
    applyStimulus(16'h0000);
    waitSweeps(3);
    checkOutput("k9_rel_done", int'(kif.key_held), 0);

    // Ghosting: "1" and "D" together are rejected.
    base = pulseCount;
    applyStimulus((16'(1) << K1) | (16'(1) << KD));
    waitSweeps(10);
    checkOutput("ghost_pulses", pulseCount - base, 0);
    checkOutput("ghost_held",   int'(kif.key_held), 0);
    checkOutput("ghost_code",   int'(kif.key_code), 9);
    applyStimulus(16'(1) << K1);
    waitSweeps(2);
    checkOutput("ghost_k1_early", pulseCount - base, 0);
    waitSweeps(1);
    checkOutput("ghost_k1_valid", int'(kif.key_valid), 1);
    checkOutput("ghost_k1_code",  int'(kif.key_code), 1);
    applyStimulus(16'h0000);
    waitSweeps(3);
    checkOutput("ghost_rel_done", int'(kif.key_held), 0);

    // No rollover: "#" held, then switched to "0".
    applyStimulus(16'(1) << KHASH);
    waitSweeps(3);
    checkOutput("hash_valid", int'(kif.key_valid), 1);
    checkOutput("hash_code",  int'(kif.key_code), 15);
    base = pulseCount;
    applyStimulus(16'(1) << K0);
    waitSweeps(6);
    checkOutput("roll_pulses", pulseCount - base, 0);
    checkOutput("roll_code",   int'(kif.key_code), 15);
    checkOutput("roll_held",   int'(kif.key_held), 1);
    applyStimulus(16'h0000);
    waitSweeps(2);
    checkOutput("roll_rel_held", int'(kif.key_held), 1);
    waitSweeps(1);
    checkOutput("roll_rel_done",   int'(kif.key_held), 0);
    checkOutput("roll_rel_pulses", pulseCount - base, 0);
    checkOutput("roll_rel_code",   int'(kif.key_code), 15);

    // Reset in the middle of debouncing "5".
    applyStimulus(16'(1) << K5);
    waitSweeps(2);
    repeat (15) @(negedge CLK_100MHz);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_col",   int'(kif.col), 4'b1110);
    checkOutput("mid_rst_code",  int'(kif.key_code), 0);
    checkOutput("mid_rst_valid", int'(kif.key_valid), 0);
    checkOutput("mid_rst_held",  int'(kif.key_held), 0);
    applyStimulus(16'h0000);
    repeat (5) @(negedge CLK_100MHz);
    rst_n = 1'b1;
    base = pulseCount;
    waitSweeps(4);
    checkOutput("post_rst_pulses", pulseCount - base, 0);
    checkOutput("post_rst_held",   int'(kif.key_held), 0);

    // Long hold of "7" for 20 sweeps.
    base = pulseCount;
    applyStimulus(16'(1) << K7);
    waitSweeps(20);
`ifdef AUTOREPEAT_EN
    checkOutput("k7_repeat_pulses", pulseCount - base, 4);
`else
    checkOutput("k7_single_pulse", pulseCount - base, 1);
`endif
    checkOutput("k7_code", int'(kif.key_code), 7);
    checkOutput("k7_held", int'(kif.key_held), 1);
    applyStimulus(16'h0000);
    waitSweeps(3);
    checkOutput("k7_rel_done", int'(kif.key_held), 0);

    checkOutput("no_double_valid", doubleCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule
